// File: rtl/spi_master_seq_if.sv
// Command/response handshake and SPI pins of the SPI sequencer.
// The slave modport is the sequencer's view; master is the bridge/requester side.
interface spi_master_seq_if #(
  parameter int unsigned SLAVES = 1,
  parameter int unsigned SW     = (SLAVES > 1) ? $clog2(SLAVES) : 1
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [SW-1:0]     cmd_slave;
  logic [6:0]        cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              spi_sclk;
  logic [SLAVES-1:0] spi_ss_n;
  logic              spi_mosi;
  logic              spi_miso;

  modport slave (
    input  cmd_valid, cmd_rnw, cmd_slave, cmd_addr, cmd_wdata, spi_miso,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_sclk, spi_ss_n, spi_mosi
  );

  modport master (
    output cmd_valid, cmd_rnw, cmd_slave, cmd_addr, cmd_wdata, spi_miso,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_sclk, spi_ss_n, spi_mosi
  );
endinterface

// File: rtl/spi_master_seq.sv
// SPI frame sequencer: one 16-bit frame {rnw, addr, data} per accepted command,
// SCLK derived from clk by CLK_DIV, mode selected by CPOL/CPHA.
module spi_master_seq #(
  parameter int unsigned CPOL    = 0,
  parameter int unsigned CPHA    = 0,
  parameter int unsigned SLAVES  = 1,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned SS_GAP  = 2
) (
  input logic           clk,
  input logic           rst,
  spi_master_seq_if.slave bus
);
  localparam logic              SCLK_IDLE = 1'(CPOL);
  localparam logic [15:0]       DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0]       GAP_LAST  = 16'(SS_GAP - 1);
  localparam logic [SLAVES-1:0] SS_ONE    = SLAVES'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap, StErr} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [5:0]        tog_q, tog_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       rx_q, rx_d;
  logic              rnw_q, rnw_d;
  logic              sclk_q, sclk_d;
  logic [SLAVES-1:0] ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  logic       accept;
  logic       div_last;
  logic [5:0] tog_next;
  logic       lead;
  logic [3:0] bit_idx;

  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign div_last      = (cnt_q == DIV_LAST);
  assign tog_next      = tog_q + 6'd1;
  // Odd toggles are leading edges; toggle k moves bit 15 - k/2 onto MOSI.
  assign lead          = tog_next[0];
  assign bit_idx       = 4'd15 - tog_next[4:1];

  assign bus.busy      = (state_q != StIdle);
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_ss_n  = ss_n_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state and registered-output logic of the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tog_d       = tog_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    rnw_d       = rnw_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rnw_d   = bus.cmd_rnw;
          frame_d = {bus.cmd_rnw, bus.cmd_addr, bus.cmd_rnw ? 8'h00 : bus.cmd_wdata};
          cnt_d   = '0;
          tog_d   = '0;
          if (32'(bus.cmd_slave) >= SLAVES) begin
            state_d     = StErr;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 8'h00;
          end else begin
            state_d = StSetup;
            ss_n_d  = ~(SS_ONE << bus.cmd_slave);
            // CPHA=0 slaves sample on the first edge, so bit 15 must already be out.
            if (CPHA == 0) mosi_d = bus.cmd_rnw;
          end
        end
      end
      StErr: state_d = StIdle;
      StSetup, StShift: begin
        cnt_d = cnt_q + 16'd1;
        if (div_last) begin
          cnt_d = '0;
          if (state_q == StShift && tog_q == 6'd32) begin
            state_d = StHold;
          end else begin
            state_d = StShift;
            sclk_d  = ~sclk_q;
            tog_d   = tog_next;
            if ((CPHA == 0) == lead) begin
              rx_d = {rx_q[14:0], bus.spi_miso};
            end else if (CPHA != 0 || tog_next != 6'd32) begin
              mosi_d = frame_q[bit_idx];
            end
          end
        end
      end
      StHold: begin
        cnt_d = cnt_q + 16'd1;
        if (div_last) begin
          cnt_d       = '0;
          state_d     = StGap;
          ss_n_d      = '1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = rnw_q ? rx_q[7:0] : 8'h00;
        end
      end
      StGap: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any frame on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tog_q       <= '0;
      frame_q     <= '0;
      rx_q        <= '0;
      rnw_q       <= 1'b0;
      sclk_q      <= SCLK_IDLE;
      ss_n_q      <= '1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tog_q       <= tog_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      rnw_q       <= rnw_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
Sequencer that drives the SPI bus behind the APB-to-SPI bridge. It accepts one command at a time over a valid/ready handshake and serialises it as a 16-bit frame on SCLK/SS/MOSI: an 8-bit header {rnw, addr[6:0]} followed by an 8-bit data byte. It samples MISO for reads and returns a single-cycle response. SCLK is generated internally from the system clock; the mode is set by CPOL/CPHA.

Parameters:
CPOL, 0, SCLK idle level (0 or 1)
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
SLAVES, 1, number of slave selects (1..8)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
SS_GAP, 2, clk cycles SS stays high between frames (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer idle, command accepted when valid&&ready
cmd_rnw  in  1  1 = read, 0 = write
cmd_slave  in  SW=max(1,clog2(SLAVES))  target slave index
cmd_addr  in  7  register address
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse, frame done
rsp_rdata  out  8  read data (0 for writes/errors)
rsp_err  out  1  cmd_slave >= SLAVES, no frame issued
busy  out  1  state != IDLE
spi_sclk  out  1  SPI clock
spi_ss_n  out  SLAVES  active-low selects
spi_mosi  out  1  master out
spi_miso  in  1  master in

Behaviour:
- Reset (while rst=1, applied next edge): state=IDLE, cmd_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, spi_sclk=CPOL, spi_ss_n=all 1, spi_mosi=0. cmd_ready=1 from the first cycle after rst drops.
- Reset mid-frame: abort immediately. SS is released and SCLK returns to CPOL on the same edge. No rsp_valid is issued for the aborted command.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; IDLE -> ERR -> IDLE.
- IDLE: cmd_ready=1. On accept, capture frame = {rnw, addr, rnw ? 8'h00 : wdata}, slave, rnw.
  - If slave >= SLAVES: go to ERR.
  - Otherwise: go to SETUP.
- ERR: lasts 1 cycle. rsp_valid=1, rsp_err=1, rsp_rdata=0. No SPI pin changes.
- SETUP: lasts CLK_DIV cycles.
  - spi_ss_n[slave]=0 from the first SETUP cycle.
  - CPHA=0: spi_mosi=frame[15] from the first SETUP cycle.
- SHIFT: 32 half-periods of CLK_DIV cycles each. spi_sclk toggles at the start of each half-period; odd toggles are leading edges, even toggles are trailing.
  - CPHA=0: sample spi_miso on each leading edge; drive the next bit on each trailing edge except the last.
  - CPHA=1: drive the next bit (MSB first) on each leading edge; sample on each trailing edge.
  - Sampling registers spi_miso on the clk edge that produces the sampling SCLK edge.
- HOLD: lasts CLK_DIV cycles, spi_sclk=CPOL. On its last cycle exit:
  - spi_ss_n = all 1, spi_mosi=0;
  - rsp_valid=1, rsp_err=0;
  - rsp_rdata = samples of bits 7..0 (MSB first) if rnw, else 0.
- GAP: lasts SS_GAP cycles with SS high, then IDLE.
- Timing: SS low for exactly 34*CLK_DIV cycles. Accept-to-rsp_valid = 1 + 34*CLK_DIV cycles. Accept-to-next-accept = 1 + 34*CLK_DIV + SS_GAP cycles.
- Only one spi_ss_n bit is ever low. spi_sclk is at CPOL whenever all SS are high.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid has no backpressure.
- cmd_* inputs are ignored while cmd_ready=0.

Test Plan:
- Reset, then idle: spi_ss_n=all 1, spi_sclk=CPOL, cmd_ready=1 on the cycle after rst deasserts; busy=0.
- CPOL=0, CPHA=0, CLK_DIV=2, write addr=7'h12 wdata=8'hA5 slave 0 -> MOSI bits sampled on rising SCLK = 16'h12A5. Exactly 16 rising edges. SS low 68 cycles. rsp_valid at accept+69 with rsp_rdata=0, rsp_err=0.
- CPOL=1, CPHA=1, read addr=7'h05, slave model returns 8'h3C on the data byte -> header sampled on rising (trailing) edges = 8'h85. rsp_rdata=8'h3C. SCLK idles high before and after the frame.
- SLAVES=4, cmd_slave=5 (SW=2 wraps; use SLAVES=3 with slave=3) -> rsp_valid with rsp_err=1 one cycle after accept; no SCLK/SS activity.
- Back-to-back commands with cmd_valid held high, SS_GAP=2 -> second accept exactly 1+68+2 cycles after the first; SS high for 2 cycles between frames.
- Assert rst at half-period 10 of a read -> next edge: SS all high, SCLK=CPOL, no rsp_valid; a new command after reset completes normally.
